// File: rtl/deflattening_layer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : deflattening_layer_pkg                                       |
// | Description : Shared types and helpers for the deflattening stage.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package deflattening_layer_pkg;

    typedef enum logic [1:0] {
        DF_IDLE = 2'd0,
        DF_EMIT = 2'd1,
        DF_DONE = 2'd2
    } deflat_state_t;

    localparam int unsigned C_DEF_BIT_SIZE = 2;
    typedef logic [C_DEF_BIT_SIZE-1:0] pixel_t;

    // One spare bit over the minimum so a counter can hold its own limit.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage : deflattening_layer_pkg
`default_nettype wire

// File: rtl/deflattening_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : deflat_sequencer                                             |
// | Description : Nested cycle/pixel/group counter chain with enable and clear.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module deflat_sequencer
    import deflattening_layer_pkg::*;
#(
    parameter int CYCLES_PER_PIXEL = 4,
    parameter int IMAGE_SIZE       = 9,
    parameter int GROUPS           = 2,
    parameter int PIX_W            = cnt_width(IMAGE_SIZE),
    parameter int GRP_W            = cnt_width(GROUPS)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             en,
    input  logic             clr,
    output logic [PIX_W-1:0] pix,
    output logic [GRP_W-1:0] grp,
    output logic             slot_first,
    output logic             last_tick
);

    localparam int C_CYC_W = cnt_width(CYCLES_PER_PIXEL);

    localparam logic [C_CYC_W-1:0] C_CYC_LAST = C_CYC_W'(CYCLES_PER_PIXEL - 1);
    localparam logic [PIX_W-1:0]   C_PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [GRP_W-1:0]   C_GRP_LAST = GRP_W'(GROUPS - 1);

    logic [C_CYC_W-1:0] r_cyc;
    logic [PIX_W-1:0]   r_pix;
    logic [GRP_W-1:0]   r_grp;

    logic w_cyc_wrap;
    logic w_pix_wrap;
    logic w_grp_last;

    assign w_cyc_wrap = (r_cyc == C_CYC_LAST);
    assign w_pix_wrap = (r_pix == C_PIX_LAST);
    assign w_grp_last = (r_grp == C_GRP_LAST);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_cyc <= '0;
            r_pix <= '0;
            r_grp <= '0;
        end else if (clr) begin
            r_cyc <= '0;
            r_pix <= '0;
            r_grp <= '0;
        end else if (en) begin
            if (w_cyc_wrap) begin
                r_cyc <= '0;
                if (w_pix_wrap) begin
                    r_pix <= '0;
                    r_grp <= w_grp_last ? '0 : r_grp + GRP_W'(1);
                end else begin
                    r_pix <= r_pix + PIX_W'(1);
                end
            end else begin
                r_cyc <= r_cyc + C_CYC_W'(1);
            end
        end
    end

    assign pix        = r_pix;
    assign grp        = r_grp;
    assign slot_first = (r_pix == '0);
    assign last_tick  = w_cyc_wrap && w_pix_wrap && w_grp_last;

endmodule : deflat_sequencer
`default_nettype wire

// File: rtl/deflattening_layer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : deflattening_layer                                           |
// | Description : Re-serialises a flat multi-image vector into lane streams.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module deflattening_layer
    import deflattening_layer_pkg::*;
#(
    parameter int BIT_SIZE         = 2,
    parameter int IMAGE_SIZE       = 9,
    parameter int NUM_OF_IMAGES    = 4,
    parameter int NUM_OF_OUTPUTS   = 2,
    parameter int CYCLES_PER_PIXEL = 4
) (
    input  logic                                             clk,
    input  logic                                             res_n,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [NUM_OF_IMAGES*IMAGE_SIZE-1:0][BIT_SIZE-1:0] in_data,
    input  logic                                             out_ready,
    output logic [NUM_OF_IMAGES-1:0]                         out_valid,
    output logic                                             out_start,
    output logic [NUM_OF_OUTPUTS-1:0][BIT_SIZE-1:0]          out_data,
    output logic                                             out_done
);

    localparam int C_GROUPS = NUM_OF_IMAGES / NUM_OF_OUTPUTS;
    localparam int C_PIX_W  = cnt_width(IMAGE_SIZE);
    localparam int C_GRP_W  = cnt_width(C_GROUPS);
    localparam int C_ELEMS  = NUM_OF_IMAGES * IMAGE_SIZE;
    localparam int C_IDX_W  = (C_ELEMS > 1) ? $clog2(C_ELEMS) : 1;

    deflat_state_t r_state;
    deflat_state_t w_next;

    logic [C_ELEMS-1:0][BIT_SIZE-1:0]        r_buf;
    logic [NUM_OF_OUTPUTS-1:0][BIT_SIZE-1:0] w_lane_data;

    logic [C_PIX_W-1:0] w_pix;
    logic [C_GRP_W-1:0] w_grp;
    logic               w_slot_first;
    logic               w_last_tick;
    logic               w_emit;
    logic               w_seq_en;
    logic               w_seq_clr;

    assign w_emit    = (r_state == DF_EMIT);
    assign w_seq_en  = w_emit && out_ready;
    assign w_seq_clr = !w_emit;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= DF_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DF_IDLE: if (in_valid)                  w_next = DF_EMIT;
            DF_EMIT: if (out_ready && w_last_tick)  w_next = DF_DONE;
            DF_DONE:                                w_next = DF_IDLE;
            default:                                w_next = DF_IDLE;
        endcase
    end

    // The buffer only loads in IDLE, so in_valid during EMIT/DONE is ignored.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_buf <= '0;
        end else if ((r_state == DF_IDLE) && in_valid) begin
            r_buf <= in_data;
        end
    end

    deflat_sequencer #(
        .CYCLES_PER_PIXEL (CYCLES_PER_PIXEL),
        .IMAGE_SIZE       (IMAGE_SIZE),
        .GROUPS           (C_GROUPS),
        .PIX_W            (C_PIX_W),
        .GRP_W            (C_GRP_W)
    ) u_sequencer (
        .clk        (clk),
        .res_n      (res_n),
        .en         (w_seq_en),
        .clr        (w_seq_clr),
        .pix        (w_pix),
        .grp        (w_grp),
        .slot_first (w_slot_first),
        .last_tick  (w_last_tick)
    );

    for (genvar j = 0; j < NUM_OF_OUTPUTS; j++) begin : g_lane
        assign w_lane_data[j] =
            r_buf[C_IDX_W'((int'(w_grp) * NUM_OF_OUTPUTS + j) * IMAGE_SIZE + int'(w_pix))];
    end

    always_comb begin
        in_ready  = (r_state == DF_IDLE);
        out_done  = (r_state == DF_DONE);
        out_start = w_emit && w_slot_first;
        out_valid = '0;
        out_data  = '0;
        if (w_emit) begin
            out_data = w_lane_data;
            for (int i = 0; i < NUM_OF_IMAGES; i++) begin
                out_valid[i] = ((i / NUM_OF_OUTPUTS) == int'(w_grp));
            end
        end
    end

endmodule : deflattening_layer
`default_nettype wire

// File: tb/tb_deflattening_layer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_deflattening_layer                                        |
// | Description : Self-checking bench with a slot-arithmetic reference model.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_deflattening_layer;

    localparam int BS    = 2;
    localparam int IS    = 9;
    localparam int NI    = 4;
    localparam int NO    = 2;
    localparam int CPP   = 4;
    localparam int G     = NI / NO;
    localparam int TOTAL = G * IS * CPP;

    typedef logic [NI*IS-1:0][BS-1:0] vec_t;

    logic                 clk = 1'b0;
    logic                 res_n;
    logic                 in_valid;
    logic                 in_ready;
    vec_t                 in_data;
    logic                 out_ready;
    logic [NI-1:0]        out_valid;
    logic                 out_start;
    logic [NO-1:0][BS-1:0] out_data;
    logic                 out_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deflattening_layer #(
        .BIT_SIZE         (BS),
        .IMAGE_SIZE       (IS),
        .NUM_OF_IMAGES    (NI),
        .NUM_OF_OUTPUTS   (NO),
        .CYCLES_PER_PIXEL (CPP)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_start (out_start),
        .out_data  (out_data),
        .out_done  (out_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < NI*IS; k++) v[k] = BS'($urandom_range(2**BS - 1));
        return v;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".out_start"}, 64'(out_start), 64'd0);
        chk({tag, ".out_data"},  64'(out_data),  64'd0);
        chk({tag, ".out_done"},  64'(out_done),  64'd0);
    endtask

    // k = number of cycles already presented with out_ready high in this stream.
    task automatic check_emit(input vec_t v, input int k);
        int slot, grp, pix;
        logic [NI-1:0]         ev;
        logic [NO-1:0][BS-1:0] ed;
        slot = k / CPP;
        grp  = slot / IS;
        pix  = slot % IS;
        for (int i = 0; i < NI; i++) ev[i] = ((i / NO) == grp);
        for (int j = 0; j < NO; j++) ed[j] = v[(grp*NO + j)*IS + pix];
        chk($sformatf("emit%0d.out_valid", k), 64'(out_valid), 64'(ev));
        chk($sformatf("emit%0d.out_data", k),  64'(out_data),  64'(ed));
        chk($sformatf("emit%0d.out_start", k), 64'(out_start), 64'(pix == 0));
        chk($sformatf("emit%0d.out_done", k),  64'(out_done),  64'd0);
        chk($sformatf("emit%0d.in_ready", k),  64'(in_ready),  64'd0);
    endtask

    // Entered at the negedge of the first EMIT cycle; leaves at the DONE cycle.
    task automatic run_stream(input vec_t v, input int stall_at, input int stall_len,
                              input bit churn);
        int k;
        k = 0;
        for (int c = 1; k < TOTAL; c++) begin
            out_ready = !((c >= stall_at) && (c < stall_at + stall_len));
            if (churn) in_data = rand_vec();
            check_emit(v, k);
            if (out_ready) k++;
            tick();
        end
        out_ready = 1'b1;
        chk("done.out_done",  64'(out_done),  64'd1);
        chk("done.out_valid", 64'(out_valid), 64'd0);
        chk("done.in_ready",  64'(in_ready),  64'd0);
        chk("done.out_start", 64'(out_start), 64'd0);
        chk("done.out_data",  64'(out_data),  64'd0);
    endtask

    task automatic capture(input vec_t v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = rand_vec();
    endtask

    initial begin
        vec_t v;
        vec_t v2;

        res_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (3) tick();
        check_idle("reset");
        res_n = 1'b1;
        tick();
        check_idle("idle");
        out_ready = 1'b0;
        tick();
        check_idle("idle_noready");
        out_ready = 1'b1;

        // Ramp pattern, unstalled: out_done at cycle 73, in_ready back at 74.
        for (int k = 0; k < NI*IS; k++) v[k] = BS'(k % 4);
        capture(v);
        run_stream(v, 0, 0, 1'b0);
        tick();
        check_idle("ramp.after");

        // Five-cycle stall inside the first group.
        v = rand_vec();
        capture(v);
        run_stream(v, 10, 5, 1'b0);
        tick();
        check_idle("stall10.after");

        // Stall straddling the group boundary.
        v = rand_vec();
        capture(v);
        run_stream(v, 36, 3, 1'b0);
        tick();
        check_idle("stall36.after");

        // in_valid held high with changing data: back-to-back vectors every 74 cycles.
        v = rand_vec();
        in_data  = v;
        in_valid = 1'b1;
        tick();
        run_stream(v, 0, 0, 1'b1);
        in_data = rand_vec();
        tick();
        check_idle("b2b.gap");
        v2 = rand_vec();
        in_data = v2;
        tick();
        run_stream(v2, 0, 0, 1'b1);
        in_valid = 1'b0;
        tick();
        check_idle("b2b.after");

        // Asynchronous reset in the middle of EMIT.
        v = rand_vec();
        capture(v);
        for (int c = 1; c < 20; c++) begin
            check_emit(v, c - 1);
            tick();
        end
        check_emit(v, 19);
        res_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick();
        check_idle("rst_held");
        res_n = 1'b1;
        tick();
        check_idle("rst_released");
        v = rand_vec();
        capture(v);
        run_stream(v, 0, 0, 1'b0);
        tick();
        check_idle("post_rst.after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_deflattening_layer
`default_nettype wire
